// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone classic arbiter: round-robin with bus lock
// while the owner holds cyc, plus a per-transfer watchdog that answers with err.
module wb_arbiter_2to1 #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  // A zero-width counter is illegal, so TIMEOUT=0 keeps a harmless 1-bit one.
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit            WD_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS_I = 2'd1, BUS_D = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic req_i, req_d, owner_cyc, owner_stb, slave_resp, fire;

  assign req_i      = iwbs_cyc_i & iwbs_stb_i;
  assign req_d      = dwbs_cyc_i & dwbs_stb_i;
  assign owner_cyc  = (state == BUS_I) ? iwbs_cyc_i : dwbs_cyc_i;
  assign owner_stb  = (state == BUS_I) ? iwbs_stb_i : dwbs_stb_i;
  assign slave_resp = wbm_ack_i | wbm_err_i;
  // A slave response in the expiry cycle beats the watchdog.
  assign fire       = WD_EN && (state != IDLE) && (cnt == CNT_MAX) && !slave_resp;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    cnt_nxt    = cnt;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    iwbs_dat_o = wbm_dat_i;
    dwbs_dat_o = wbm_dat_i;

    unique case (state)
      IDLE: begin
        // Ties go to whichever port was not granted last.
        if (req_i && (!req_d || last_d)) begin
          state_nxt  = BUS_I;
          last_d_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (req_d) begin
          state_nxt  = BUS_D;
          last_d_nxt = 1'b1;
          cnt_nxt    = '0;
        end
      end
      BUS_I: begin
        wbm_cyc_o  = iwbs_cyc_i & ~fire;
        wbm_stb_o  = iwbs_stb_i & ~fire;
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = 4'hF;
        iwbs_ack_o = wbm_ack_i & iwbs_cyc_i;
        iwbs_err_o = (wbm_err_i & iwbs_cyc_i) | fire;
      end
      BUS_D: begin
        wbm_cyc_o  = dwbs_cyc_i & ~fire;
        wbm_stb_o  = dwbs_stb_i & ~fire;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        dwbs_ack_o = wbm_ack_i & dwbs_cyc_i;
        dwbs_err_o = (wbm_err_i & dwbs_cyc_i) | fire;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      if (slave_resp || fire) cnt_nxt = '0;
      else if (owner_stb)     cnt_nxt = cnt + 1'b1;
      if (!owner_cyc)         state_nxt = IDLE;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: a TIMEOUT=4 instance is scoreboarded for
// every master response; a TIMEOUT=0 twin on the same stimulus must never time out.
module tb_wb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] iwbs_addr_i, dwbs_addr_i, dwbs_dat_i, wbm_dat_i;
  logic        iwbs_cyc_i, iwbs_stb_i, dwbs_cyc_i, dwbs_stb_i, dwbs_we_i;
  logic [3:0]  dwbs_sel_i;
  logic        wbm_ack_i, wbm_err_i;

  logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_addr_o, wbm_dat_o;
  logic        iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;

  logic [31:0] z_iwbs_dat_o, z_dwbs_dat_o, z_wbm_addr_o, z_wbm_dat_o;
  logic        z_iwbs_ack_o, z_iwbs_err_o, z_dwbs_ack_o, z_dwbs_err_o;
  logic [3:0]  z_wbm_sel_o;
  logic        z_wbm_cyc_o, z_wbm_stb_o, z_wbm_we_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  resp;   // {i_ack, i_err, d_ack, d_err}
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .iwbs_addr_i(iwbs_addr_i), .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i),
    .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
    .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  wb_arbiter_2to1 #(.TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i),
    .iwbs_addr_i(iwbs_addr_i), .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i),
    .iwbs_dat_o(z_iwbs_dat_o), .iwbs_ack_o(z_iwbs_ack_o), .iwbs_err_o(z_iwbs_err_o),
    .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_dat_o(z_dwbs_dat_o), .dwbs_ack_o(z_dwbs_ack_o), .dwbs_err_o(z_dwbs_err_o),
    .wbm_addr_o(z_wbm_addr_o), .wbm_dat_o(z_wbm_dat_o), .wbm_sel_o(z_wbm_sel_o),
    .wbm_cyc_o(z_wbm_cyc_o), .wbm_stb_o(z_wbm_stb_o), .wbm_we_o(z_wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic sb_push(input logic [3:0] resp, input logic [31:0] data);
    exp_t e;
    e.resp = resp;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Any response seen on the master side must match the head of the queue;
  // with nothing queued, no response may appear.
  task automatic sb_check(input string tag);
    exp_t e;
    e.resp = 4'b0000;
    e.data = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({tag, "_resp"}, {28'd0, iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o}, {28'd0, e.resp});
    if (e.resp[3]) check({tag, "_idat"}, iwbs_dat_o, e.data);
    if (e.resp[1]) check({tag, "_ddat"}, dwbs_dat_o, e.data);
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_i       = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_err_i   = 1'b0;
    wbm_dat_i   = '0;
    iwbs_addr_i = 32'h8000_0000;
    iwbs_cyc_i  = 1'b1;
    iwbs_stb_i  = 1'b1;
    dwbs_addr_i = 32'h8000_0100;
    dwbs_dat_i  = 32'hDEAD_BEEF;
    dwbs_sel_i  = 4'b0011;
    dwbs_we_i   = 1'b1;
    dwbs_cyc_i  = 1'b1;
    dwbs_stb_i  = 1'b1;

    // Reset held with both masters requesting: the shared bus stays idle.
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
      sb_check("rst");
    end
    step(); rst_i = 1'b1;

    // Tie after reset: I is granted, one cycle after the request is sampled.
    step(); #1;
    check("grant_i_stb", {31'd0, wbm_stb_o}, 32'd1);
    check("grant_i_addr", wbm_addr_o, 32'h8000_0000);
    check("grant_i_we", {31'd0, wbm_we_o}, 32'd0);
    check("grant_i_sel", {28'd0, wbm_sel_o}, 32'hF);
    check("grant_i_dat", wbm_dat_o, 32'd0);
    sb_check("grant_i");

    // Slave acks the I read; D write is held off.
    step(); wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0013; sb_push(4'b1000, 32'h13); #1;
    sb_check("i_read");
    check("d_dat_mirror", dwbs_dat_o, 32'h13);

    step(); wbm_ack_i = 1'b0; wbm_dat_i = '0; iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0; #1;
    check("i_release_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    sb_check("i_release");

    step(); #1;
    check("dead_cycle_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    sb_check("dead_cycle");

    step(); #1;
    check("d_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check("d_addr", wbm_addr_o, 32'h8000_0100);
    check("d_wdat", wbm_dat_o, 32'hDEAD_BEEF);
    check("d_sel", {28'd0, wbm_sel_o}, 32'h3);
    check("d_we", {31'd0, wbm_we_o}, 32'd1);
    sb_check("d_wait");

    step(); wbm_ack_i = 1'b1; sb_push(4'b0010, 32'd0); #1;
    sb_check("d_write");

    // D releases while I requests; then a fresh tie goes to I (last grant was D).
    step(); wbm_ack_i = 1'b0; dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
    iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = 32'h8000_0040;
    step(); dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; #1;
    check("tie_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    // Silent slave: watchdog fires at G+4 and again 5 cycles later on retry.
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 4 || k == 9) sb_push(4'b0100, 32'd0);
      #1;
      if (k == 0) check("tie2_addr", wbm_addr_o, 32'h8000_0040);
      check($sformatf("wd_stb_k%0d", k), {31'd0, wbm_stb_o}, (k == 4 || k == 9) ? 32'd0 : 32'd1);
      sb_check($sformatf("wd_k%0d", k));
      check($sformatf("wd0_err_k%0d", k), {31'd0, z_iwbs_err_o}, 32'd0);
      check($sformatf("wd0_stb_k%0d", k), {31'd0, z_wbm_stb_o}, 32'd1);
    end

    step(); iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
    step(); #1;
    check("wd_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    // D granted; slave acks exactly at G+4, so the ack wins over the watchdog.
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) begin
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0055; sb_push(4'b0010, 32'h55);
      end
      #1;
      if (k == 0) check("d2_addr", wbm_addr_o, 32'h8000_0100);
      sb_check($sformatf("race_k%0d", k));
    end
    step(); wbm_ack_i = 1'b0; #1;
    sb_check("after_race");

    // Reset during a D wait: the transfer is dropped and a late ack is ignored.
    step(); rst_i = 1'b0;
    step(); wbm_ack_i = 1'b1; #1;
    check("rst_mid_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    sb_check("rst_mid");
    step(); wbm_ack_i = 1'b0; rst_i = 1'b1; dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
    step(); #1;
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Shares one single-port Wishbone classic slave (memory or bus) between the core's instruction master (read-only) and data master.
- Arbitration is round-robin with bus lock while the owner holds cyc.
- A per-transfer watchdog converts a slave that never answers into a Wishbone error to the owning master.
- Sits between the CPU master ports and a single-port RAM/interconnect in testbench and SoC tops.

Parameters:
- TIMEOUT, 255: wait cycles without ack/err before the watchdog fires; 0 disables the watchdog.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-low reset
- iwbs_addr_i  input  32  I-master address
- iwbs_cyc_i  input  1  I-master cycle
- iwbs_stb_i  input  1  I-master strobe
- iwbs_dat_o  output  32  read data to I-master
- iwbs_ack_o  output  1  ack to I-master
- iwbs_err_o  output  1  error to I-master
- dwbs_addr_i  input  32  D-master address
- dwbs_dat_i  input  32  D-master write data
- dwbs_sel_i  input  4  D-master byte select
- dwbs_cyc_i  input  1  D-master cycle
- dwbs_stb_i  input  1  D-master strobe
- dwbs_we_i  input  1  D-master write enable
- dwbs_dat_o  output  32  read data to D-master
- dwbs_ack_o  output  1  ack to D-master
- dwbs_err_o  output  1  error to D-master
- wbm_addr_o  output  32  shared address
- wbm_dat_o  output  32  shared write data
- wbm_sel_o  output  4  shared byte select
- wbm_cyc_o  output  1  shared cycle
- wbm_stb_o  output  1  shared strobe
- wbm_we_o  output  1  shared write enable
- wbm_dat_i  input  32  slave read data
- wbm_ack_i  input  1  slave ack
- wbm_err_i  input  1  slave error

Behaviour:
- Interface: single clock clk_i; rst_i is synchronous and active-low.
- Reset (rst_i=0 at a rising edge):
  - state=IDLE, cnt=0, last_grant=D.
  - From the following cycle all wbm_* outputs are 0 and all ack/err outputs are 0.
  - Reset mid-transfer abandons the transfer; no ack or err is issued.
- Request condition: a port requests when cyc_i & stb_i.
- FSM states: IDLE, BUS_I, BUS_D (registered).
- IDLE transitions:
  - Only I requests -> BUS_I.
  - Only D requests -> BUS_D.
  - Both request -> the port that is not last_grant wins.
  - On entry to BUS_x, last_grant<=x and cnt<=0.
- IDLE outputs: wbm_cyc_o=wbm_stb_o=0. Grant latency is 1 cycle: a request sampled at edge N gives wbm_stb_o=1 in the cycle after N.
- BUS_I forwarding:
  - wbm_cyc_o/stb_o/addr_o = iwbs_*.
  - wbm_we_o=0, wbm_sel_o=4'hF, wbm_dat_o=0.
- BUS_D forwarding: cyc/stb/addr/dat/sel/we taken combinationally from dwbs_*.
- Response routing:
  - wbm_ack_i and wbm_err_i go to the owner only; the non-owner's ack/err are 0.
  - iwbs_dat_o and dwbs_dat_o both equal wbm_dat_i at all times.
- Non-owner requests: held off with no ack/err until granted.
- Release: owner cyc_i=0 at an edge -> IDLE. There is one dead cycle (wbm_cyc_o=0) before any new grant, including a re-grant to the same port.
- Watchdog counter (cnt, width $clog2(TIMEOUT+1)):
  - In BUS_x, increments each cycle owner stb_i=1 and wbm_ack_i=0 and wbm_err_i=0.
  - Cleared on ack, on err, on grant, and on timeout.
- Watchdog firing (TIMEOUT>0 and cnt==TIMEOUT):
  - Owner err_o=1 for that cycle; wbm_stb_o and wbm_cyc_o are forced to 0 that cycle.
  - cnt clears; the state stays BUS_x, so the owner may retry or drop cyc.
- Ack and timeout in the same cycle: the slave response wins; ack (or slave err) is forwarded and no watchdog err is issued.
- Watchdog timing: with stb held from grant cycle G and no ack, err is asserted in cycle G+TIMEOUT.
- Owner drops cyc mid-wait: any late slave ack is not forwarded (wbm_cyc_o already low).

Test Plan:
- Reset: rst_i=0 for 2 cycles, both masters requesting -> wbm_cyc_o=wbm_stb_o=0 and all ack/err=0 throughout. After release, I is granted first.
- I-only read at 0x8000_0000, slave acks 1 cycle after stb with 0x0000_0013 -> wbm_stb_o rises 1 cycle after request with wbm_we_o=0 and wbm_sel_o=4'hF; iwbs_ack_o=1 with iwbs_dat_o=0x13; dwbs_ack_o=0.
- Tie after reset -> BUS_I. I drops cyc -> 1 IDLE cycle -> BUS_D. Next simultaneous tie -> I wins again (last_grant=D).
- D write 0xDEADBEEF, sel 4'b0011, at 0x8000_0100, issued while I owns the bus -> no dwbs_ack_o until I releases. After grant, wbm_dat_o, wbm_sel_o and wbm_we_o=1 match and dwbs_ack_o follows the slave ack.
- TIMEOUT=4, slave silent -> owner err_o pulse at G+4 with wbm_stb_o=0 that cycle and no ack. With TIMEOUT=0 the same stimulus never produces err.
- TIMEOUT=4, slave ack exactly at G+4 -> ack forwarded, err_o=0. Separately, rst_i=0 during a D wait -> IDLE next cycle, dwbs_ack_o/err_o stay 0.
